btn_press_decoder: RTL and testbench

//  Consumes btn_sync from sync_debounce and classifies each press: short, double, or long (hold).

---
 rtl/btn_pkg.sv | 23 ++
 rtl/btn_edge_detect.sv | 29 ++
 rtl/btn_press_decoder.sv | 121 ++++++++++++
 tb/tb_btn_press_decoder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button press decoder.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        LONG,
        WAIT_REL
    } btn_state_t;

    // Defaults assume a 100 MHz clock.
    localparam int DEF_LONG_CYCLES   = 50_000_000;
    localparam int DEF_GAP_CYCLES    = 25_000_000;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registered edge detector: q is d delayed one cycle; rise/fall compare them.
module btn_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall,
    output logic q
);

    logic d_q;
    logic d_d;

    // Next value of the delayed copy is simply the current input.
    always_comb begin
        d_d = d;
    end

    // Delay register; clears to 0 so a level held through reset reads as a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d_d;
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;
    assign q    = d_q;

endmodule

// File: rtl/btn_press_decoder.sv
// Classifies debounced button presses into short / double / long events and
// emits an auto-repeat pulse while a long press is held. All outputs registered.
module btn_press_decoder
    import btn_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_sync,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic rep_pulse,
    output logic busy
);

    localparam int CNT_W = $clog2(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES) + 1);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic rise, fall, btn_q;

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;

    btn_edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (btn_sync),
        .rise (rise),
        .fall (fall),
        .q    (btn_q)
    );

    // Next-state, timer and pulse decode; fall/rise take priority over timeouts.
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        rep_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) state_d = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_d = GAP;
                end else if (btn_q && timer_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                end
            end
            GAP: begin
                if (rise) begin
                    double_d = 1'b1;
                    state_d  = WAIT_REL;
                end else if (timer_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (timer_q == REP_LAST) begin
                    rep_d = 1'b1;
                end
            end
            WAIT_REL: begin
                if (fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Timer restarts on any state change or repeat tick, otherwise saturates.
        if (state_d != state_q || rep_d) begin
            timer_d = '0;
        end else if (timer_q != {CNT_W{1'b1}}) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

    // State, timer and registered event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            rep_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            rep_q    <= rep_d;
        end
    end

    assign short_press  = short_q;
    assign double_press = double_q;
    assign long_press   = long_q;
    assign rep_pulse    = rep_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_btn_press_decoder.sv
// Directed bench for btn_press_decoder with shortened timing constants.
module tb_btn_press_decoder;

    localparam int LONG_C = 20;
    localparam int GAP_C  = 10;
    localparam int REP_C  = 8;

    // Pulse vector order: {short, double, long, rep}
    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_SHORT = 4'b1000;
    localparam logic [3:0] P_DBL   = 4'b0100;
    localparam logic [3:0] P_LONG  = 4'b0010;
    localparam logic [3:0] P_REP   = 4'b0001;

    logic clk = 1'b0;
    logic rst;
    logic btn_sync;
    logic short_press, double_press, long_press, rep_pulse, busy;

    int total = 0;
    int bad   = 0;

    btn_press_decoder #(
        .LONG_CYCLES   (LONG_C),
        .GAP_CYCLES    (GAP_C),
        .REPEAT_CYCLES (REP_C)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_sync     (btn_sync),
        .short_press  (short_press),
        .double_press (double_press),
        .long_press   (long_press),
        .rep_pulse    (rep_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] pulses();
        return {short_press, double_press, long_press, rep_pulse};
    endfunction

    task automatic chk_p(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = pulses();
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: pulses got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk_busy(input string tag, input logic exp);
        total++;
        assert (busy === exp) else begin
            bad++;
            $error("FAIL %s: busy got %b want %b", tag, busy, exp);
        end
    endtask

    // One clock edge, then check the pulse vector just after it.
    task automatic tick(input string tag, input logic [3:0] exp);
        @(posedge clk);
        #1;
        chk_p(tag, exp);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, P_NONE);
    endtask

    initial begin
        // Reset with button held: nothing may pulse, busy stays low.
        rst = 1'b1;
        btn_sync = 1'b1;
        #1;
        chk_busy("rst_busy0", 1'b0);
        chk_p("rst_pulses0", P_NONE);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_p("rst_pulses", P_NONE);
            chk_busy("rst_busy", 1'b0);
        end
        rst = 1'b0;
        // First edge after reset sees the held level as a rise.
        tick("pwrup_rise", P_NONE);
        chk_busy("pwrup_press1", 1'b1);
        // Release: fall next edge, short 10 edges later.
        btn_sync = 1'b0;
        ticks("pwrup_gap", 10);
        tick("pwrup_short", P_SHORT);
        ticks("pwrup_idle", 3);
        chk_busy("pwrup_done", 1'b0);

        // Short press: high 5, low -> short 10 cycles after the fall.
        btn_sync = 1'b1;
        ticks("short_hold", 5);
        btn_sync = 1'b0;
        ticks("short_gap", 10);
        tick("short_pulse", P_SHORT);
        ticks("short_after", 4);
        chk_busy("short_idle", 1'b0);

        // Double press: high 5, low 4, high 5, low.
        btn_sync = 1'b1;
        ticks("dbl_hold1", 5);
        btn_sync = 1'b0;
        ticks("dbl_gap", 4);
        btn_sync = 1'b1;
        tick("dbl_pulse", P_DBL);
        chk_busy("dbl_waitrel", 1'b1);
        ticks("dbl_hold2", 4);
        btn_sync = 1'b0;
        ticks("dbl_after", 14);
        chk_busy("dbl_idle", 1'b0);

        // Long + repeat: high 45 -> long@20, rep@28,36,44.
        btn_sync = 1'b1;
        ticks("long_pre", LONG_C);
        tick("long_pulse", P_LONG);
        ticks("rep_w1", REP_C - 1);
        tick("rep_1", P_REP);
        ticks("rep_w2", REP_C - 1);
        tick("rep_2", P_REP);
        ticks("rep_w3", REP_C - 1);
        tick("rep_3", P_REP);
        btn_sync = 1'b0;
        ticks("long_release", 14);
        chk_busy("long_idle", 1'b0);

        // Boundary: fall exactly at hold cycle 20 counts as short.
        btn_sync = 1'b1;
        ticks("bnd_hold", LONG_C);
        btn_sync = 1'b0;
        tick("bnd_fall_no_long", P_NONE);
        ticks("bnd_gap", GAP_C - 1);
        tick("bnd_short", P_SHORT);
        ticks("bnd_after", 3);

        // Boundary: repress exactly at gap cycle 10 is still a double.
        btn_sync = 1'b1;
        ticks("bgap_hold", 5);
        btn_sync = 1'b0;
        ticks("bgap_gap", GAP_C);
        btn_sync = 1'b1;
        tick("bgap_double", P_DBL);
        ticks("bgap_hold2", 3);
        btn_sync = 1'b0;
        ticks("bgap_after", 14);
        chk_busy("bgap_idle", 1'b0);

        // Reset mid-GAP aborts with no short_press.
        btn_sync = 1'b1;
        ticks("rgap_hold", 5);
        btn_sync = 1'b0;
        ticks("rgap_gap", 2);
        chk_busy("rgap_busy_before", 1'b1);
        rst = 1'b1;
        #1;
        chk_busy("rgap_busy_async", 1'b0);
        chk_p("rgap_pulses_async", P_NONE);
        ticks("rgap_in_rst", 2);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick("rgap_no_short", P_NONE);
            chk_busy("rgap_idle", 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
